// File: rtl/adder8_cla_pwr.sv
// rtl/adder8_cla_pwr.sv - registered 8-bit carry-lookahead adder with output-toggle counter
// Optional feature macro: ADDER_TRANS_CNT_EN (builds the transition counter when defined)
module adder8_cla_pwr #(
  parameter int PWR_CNTR_ID = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [7:0]       oprA,
  input  logic [7:0]       oprB,
  input  logic             cin,
  input  logic             in_valid,
  input  logic             trans_clr,
  output logic [7:0]       suma,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  output logic [CNT_W-1:0] trans_count,
  output logic [7:0]       cntr_id
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  logic       w_grp0_g;
  logic       w_grp0_p;
  logic       w_grp1_g;
  logic       w_grp1_p;
  logic [7:0] w_sum;
  logic       w_ovf;

  logic [7:0] r_suma;
  logic       r_cout;
  logic       r_ovf;
  logic       r_out_valid;

  assign w_g = oprA & oprB;
  assign w_p = oprA ^ oprB;

  // Lower group: carries c1..c3 and group generate/propagate, all flat two-level terms
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_grp0_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_grp0_p = &w_p[3:0];

  // Upper-group carry-in comes straight from the lower group's G/P, not through c3
  assign w_c[4] = w_grp0_g | (w_grp0_p & cin);

  // Upper group: same structure driven by c4
  assign w_c[5] = w_g[4] | (w_p[4] & w_c[4]);
  assign w_c[6] = w_g[5] | (w_p[5] & w_g[4]) | (w_p[5] & w_p[4] & w_c[4]);
  assign w_c[7] = w_g[6] | (w_p[6] & w_g[5]) | (w_p[6] & w_p[5] & w_g[4])
                | (w_p[6] & w_p[5] & w_p[4] & w_c[4]);
  assign w_grp1_g = w_g[7] | (w_p[7] & w_g[6]) | (w_p[7] & w_p[6] & w_g[5])
                  | (w_p[7] & w_p[6] & w_p[5] & w_g[4]);
  assign w_grp1_p = &w_p[7:4];

  // Carry out expanded over both groups so it does not wait on c4
  assign w_c[8] = w_grp1_g | (w_grp1_p & w_grp0_g) | (w_grp1_p & w_grp0_p & cin);

  assign w_sum = w_p ^ w_c[7:0];
  assign w_ovf = w_c[7] ^ w_c[8];

  // Result registers: load on in_valid, hold otherwise; out_valid is a one-cycle echo of in_valid
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_suma      <= 8'd0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_suma <= w_sum;
        r_cout <= w_c[8];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign suma      = r_suma;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
  assign cntr_id   = 8'(PWR_CNTR_ID);

`ifdef ADDER_TRANS_CNT_EN
  logic [8:0]       w_toggle;
  logic [3:0]       w_pop;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W:0]   w_ext;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_cnt;

  // Bits of {cout,suma} that flip when the new result is loaded; ovf is not counted
  assign w_toggle = {r_cout, r_suma} ^ {w_c[8], w_sum};

  // Popcount of the toggle vector (0..9)
  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 9; i++) begin
      w_pop = w_pop + {3'd0, w_toggle[i]};
    end
  end

  // A clear on the same edge restarts the count, so that edge's toggles are counted from zero
  assign w_base     = trans_clr ? '0 : r_cnt;
  assign w_ext      = {1'b0, w_base} + {{(CNT_W - 3){1'b0}}, w_pop};
  assign w_cnt_next = w_ext[CNT_W] ? {CNT_W{1'b1}} : w_ext[CNT_W-1:0];

  // Saturating activity counter; reset dominates clear, clear dominates hold
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_cnt_next;
    end else if (trans_clr) begin
      r_cnt <= '0;
    end
  end

  assign trans_count = r_cnt;
`else
  logic w_unused_trans_clr;

  assign w_unused_trans_clr = trans_clr;
  assign trans_count        = '0;
`endif

endmodule

// File: tb/tb_adder8_cla_pwr.sv
// tb/tb_adder8_cla_pwr.sv - scoreboard bench for adder8_cla_pwr
module tb_adder8_cla_pwr;

`ifdef ADDER_TRANS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [7:0]  oprA = 8'd0;
  logic [7:0]  oprB = 8'd0;
  logic        cin = 1'b0;
  logic        in_valid = 1'b0;
  logic        trans_clr = 1'b0;

  logic [7:0]  suma, suma8;
  logic        cout, cout8;
  logic        ovf, ovf8;
  logic        out_valid, out_valid8;
  logic [31:0] trans_count;
  logic [7:0]  trans_count8;
  logic [7:0]  cntr_id, cntr_id8;

  adder8_cla_pwr #(.PWR_CNTR_ID(5), .CNT_W(32)) dut (
    .clk(clk), .reset_L(reset_L), .oprA(oprA), .oprB(oprB), .cin(cin),
    .in_valid(in_valid), .trans_clr(trans_clr), .suma(suma), .cout(cout),
    .ovf(ovf), .out_valid(out_valid), .trans_count(trans_count), .cntr_id(cntr_id)
  );

  adder8_cla_pwr #(.PWR_CNTR_ID(8'hA7), .CNT_W(8)) dut8 (
    .clk(clk), .reset_L(reset_L), .oprA(oprA), .oprB(oprB), .cin(cin),
    .in_valid(in_valid), .trans_clr(trans_clr), .suma(suma8), .cout(cout8),
    .ovf(ovf8), .out_valid(out_valid8), .trans_count(trans_count8), .cntr_id(cntr_id8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sum;
    logic        co;
    logic        ov;
    longint      cnt;
    longint      cnt8;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;

  logic [8:0]  m_out = 9'd0;
  logic        m_ovf = 1'b0;
  longint      m_cnt = 0;
  longint      m_cnt8 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic v, input logic clr, input logic rn);
    logic [8:0] nw;
    int         pop;
    exp_t       e;
    oprA = a; oprB = b; cin = c; in_valid = v; trans_clr = clr; reset_L = rn;
    @(posedge clk);
    if (!rn) begin
      m_out = 9'd0; m_ovf = 1'b0; m_cnt = 0; m_cnt8 = 0;
      sb.delete();
    end else begin
      if (clr) begin
        m_cnt = 0; m_cnt8 = 0;
      end
      if (v) begin
        nw     = {1'b0, a} + {1'b0, b} + {8'd0, c};
        pop    = $countones(nw ^ m_out);
        m_ovf  = (a[7] == b[7]) && (nw[7] != a[7]);
        m_out  = nw;
        m_cnt  = sat(m_cnt + pop, 64'hFFFF_FFFF);
        m_cnt8 = sat(m_cnt8 + pop, 255);
        e.sum  = nw[7:0]; e.co = nw[8]; e.ov = m_ovf;
        e.cnt  = CNT_EN ? m_cnt : 0;
        e.cnt8 = CNT_EN ? m_cnt8 : 0;
        sb.push_back(e);
      end
    end
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, rn & v});
    check("out_valid8", {63'd0, out_valid8}, {63'd0, rn & v});
    if (out_valid) begin
      check("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("suma", {56'd0, suma}, {56'd0, e.sum});
        check("cout", {63'd0, cout}, {63'd0, e.co});
        check("ovf", {63'd0, ovf}, {63'd0, e.ov});
        check("trans_count", {32'd0, trans_count}, e.cnt);
        check("suma8", {56'd0, suma8}, {56'd0, e.sum});
        check("trans_count8", {56'd0, trans_count8}, e.cnt8);
      end
    end else begin
      check("hold_suma", {56'd0, suma}, {56'd0, m_out[7:0]});
      check("hold_cout", {63'd0, cout}, {63'd0, m_out[8]});
      check("hold_ovf", {63'd0, ovf}, {63'd0, m_ovf});
      check("hold_count", {32'd0, trans_count}, CNT_EN ? m_cnt : 0);
      check("hold_count8", {56'd0, trans_count8}, CNT_EN ? m_cnt8 : 0);
    end
  endtask

  initial begin
    longint saved;

    // Reset with in_valid and trans_clr active
    step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0);
    step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    check("rst_suma", {56'd0, suma}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_count", {32'd0, trans_count}, 64'd0);
    check("cntr_id", {56'd0, cntr_id}, 64'd5);
    check("cntr_id8", {56'd0, cntr_id8}, 64'hA7);

    // Full carry chain from reset state
    step(8'd255, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("fc1_suma", {56'd0, suma}, 64'd0);
    check("fc1_cout", {63'd0, cout}, 64'd1);
    check("fc1_count", {32'd0, trans_count}, CNT_EN ? 64'd1 : 64'd0);
    step(8'd255, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("fc2_suma", {56'd0, suma}, 64'd255);
    check("fc2_cout", {63'd0, cout}, 64'd0);
    check("fc2_count", {32'd0, trans_count}, CNT_EN ? 64'd10 : 64'd0);

    // Basic adds, then an idle cycle so out_valid must drop
    step(8'd200, 8'd100, 1'b0, 1'b1, 1'b0, 1'b1);
    check("add1_suma", {56'd0, suma}, 64'd44);
    check("add1_cout", {63'd0, cout}, 64'd1);
    check("add1_ovf", {63'd0, ovf}, 64'd0);
    step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'd100, 8'd50, 1'b0, 1'b1, 1'b0, 1'b1);
    check("add2_suma", {56'd0, suma}, 64'd150);
    check("add2_cout", {63'd0, cout}, 64'd0);
    check("add2_ovf", {63'd0, ovf}, 64'd1);

    // Hold for 5 cycles with changing operands
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
    end
    check("hold5_suma", {56'd0, suma}, 64'd150);

    // Identical operands twice: second adds nothing
    step(8'd10, 8'd20, 1'b0, 1'b1, 1'b0, 1'b1);
    saved = CNT_EN ? m_cnt : 0;
    step(8'd10, 8'd20, 1'b0, 1'b1, 1'b0, 1'b1);
    check("repeat_count", {32'd0, trans_count}, saved);

    // Clear with in_valid: 0x01E -> 0x019 flips 3 bits
    step(8'd25, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_count", {32'd0, trans_count}, CNT_EN ? 64'd3 : 64'd0);
    check("clr_count8", {56'd0, trans_count8}, CNT_EN ? 64'd3 : 64'd0);

    // Drive the 8-bit counter into saturation with 9-bit swings
    for (int i = 0; i < 30; i++) begin
      step(8'd255, 8'd0, 1'(i % 2 == 0), 1'b1, 1'b0, 1'b1);
    end
    check("sat_count8", {56'd0, trans_count8}, CNT_EN ? 64'd255 : 64'd0);
    step(8'd255, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_hold8", {56'd0, trans_count8}, CNT_EN ? 64'd255 : 64'd0);

    // Random sweep
    for (int i = 0; i < 100; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b1);
    end

    // Mid-operation reset beats in_valid and trans_clr
    step(8'd77, 8'd99, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst2_suma", {56'd0, suma}, 64'd0);
    check("rst2_count", {32'd0, trans_count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
